// File: rtl/qc_ldpc_pkg.sv
// Shared types and helpers for the QC-LDPC datapath blocks.
package qc_ldpc_pkg;

  localparam int MAXZ_DEFAULT  = 16;
  localparam int TAG_W_DEFAULT = 8;
  localparam int SW_DEFAULT    = $clog2(MAXZ_DEFAULT);
  localparam int ZW_DEFAULT    = $clog2(MAXZ_DEFAULT + 1);

  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_e;

  typedef struct packed {
    logic [MAXZ_DEFAULT-1:0]  data;
    logic [SW_DEFAULT-1:0]    shift;
    logic [ZW_DEFAULT-1:0]    z;
    shift_dir_e               dir;
    logic [TAG_W_DEFAULT-1:0] tag;
  } shifter_beat_t;

  // Number of pipeline levels needed to consume log_w amount bits, per_cycle at a time.
  function automatic int clog2_ceil_div(input int log_w, input int per_cycle);
    return (log_w + per_cycle - 1) / per_cycle;
  endfunction

endpackage

// File: rtl/qc_barrel_stage.sv
// One pipeline level of the dual barrel shifter: applies N levels, starting at
// amount bit OFFSET, to A (right shift by r) and B (left shift by rc), then registers.
module qc_barrel_stage import qc_ldpc_pkg::*; #(
  parameter int MAXZ   = MAXZ_DEFAULT,
  parameter int SW     = SW_DEFAULT,
  parameter int TAG_W  = TAG_W_DEFAULT,
  parameter int OFFSET = 0,
  parameter int N      = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             src_valid,
  input  logic [MAXZ-1:0]  src_a,
  input  logic [MAXZ-1:0]  src_b,
  input  logic [MAXZ-1:0]  src_mask,
  input  logic [SW-1:0]    src_r,
  input  logic [SW-1:0]    src_rc,
  input  logic             src_err,
  input  logic [TAG_W-1:0] src_tag,
  output logic             dst_valid,
  output logic [MAXZ-1:0]  dst_a,
  output logic [MAXZ-1:0]  dst_b,
  output logic [MAXZ-1:0]  dst_mask,
  output logic [SW-1:0]    dst_r,
  output logic [SW-1:0]    dst_rc,
  output logic             dst_err,
  output logic [TAG_W-1:0] dst_tag
);

  logic [MAXZ-1:0] a_next;
  logic [MAXZ-1:0] b_next;

  always_comb begin
    a_next = src_a;
    b_next = src_b;
    for (int j = 0; j < N; j++) begin
      if (src_r[OFFSET + j])  a_next = a_next >> (32'd1 << (OFFSET + j));
      if (src_rc[OFFSET + j]) b_next = b_next << (32'd1 << (OFFSET + j));
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      dst_valid <= 1'b0;
      dst_a     <= '0;
      dst_b     <= '0;
      dst_mask  <= '0;
      dst_r     <= '0;
      dst_rc    <= '0;
      dst_err   <= 1'b0;
      dst_tag   <= '0;
    end else if (en) begin
      dst_valid <= src_valid;
      dst_a     <= a_next;
      dst_b     <= b_next;
      dst_mask  <= src_mask;
      dst_r     <= src_r;
      dst_rc    <= src_rc;
      dst_err   <= src_err;
      dst_tag   <= src_tag;
    end
  end

endmodule

// File: rtl/qc_var_z_shifter.sv
// Pipelined variable-Z circular shifter: rotates the low in_z bits of a MAXZ-wide
// word by a runtime amount, with global-stall valid/ready handshaking and a tag.
module qc_var_z_shifter import qc_ldpc_pkg::*; #(
  parameter int  MAXZ             = MAXZ_DEFAULT,
  parameter int  STAGES_PER_CYCLE = 2,
  parameter int  TAG_W            = TAG_W_DEFAULT,
  localparam int LOG              = $clog2(MAXZ),
  localparam int SW               = LOG,
  localparam int ZW               = $clog2(MAXZ + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAXZ-1:0]  in_data,
  input  logic [SW-1:0]    in_shift,
  input  logic [ZW-1:0]    in_z,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAXZ-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int P   = clog2_ceil_div(LOG, STAGES_PER_CYCLE);
  localparam int LAT = P + 2;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [MAXZ-1:0] mask_c;
  logic [ZW-1:0]   shift_z;
  logic [ZW-1:0]   r_full;
  logic [ZW-1:0]   rc_full;
  logic            err_c;

  // Left rotation by s is folded into a right rotation by Z-s, so the shifter
  // only ever sees one direction; rc is the complementary left amount for the wrap.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < MAXZ; i++) begin
      mask_c[i] = (ZW'(i) < in_z);
    end
    shift_z = ZW'(in_shift);
    if ((shift_dir_e'(in_dir) == SHIFT_LEFT) && (shift_z != '0)) begin
      r_full = in_z - shift_z;
    end else begin
      r_full = shift_z;
    end
    rc_full = (r_full == '0) ? '0 : (in_z - r_full);
    err_c   = (in_z == '0) || (in_z > ZW'(MAXZ)) || (shift_z >= in_z);
  end

  logic             s0_valid;
  logic [MAXZ-1:0]  s0_x;
  logic [MAXZ-1:0]  s0_mask;
  logic [SW-1:0]    s0_r;
  logic [SW-1:0]    s0_rc;
  logic             s0_err;
  logic [TAG_W-1:0] s0_tag;

  always_ff @(posedge CLK) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
      s0_mask  <= '0;
      s0_r     <= '0;
      s0_rc    <= '0;
      s0_err   <= 1'b0;
      s0_tag   <= '0;
    end else if (adv) begin
      s0_valid <= in_valid;
      s0_x     <= in_data & mask_c;
      s0_mask  <= mask_c;
      s0_r     <= SW'(r_full);
      s0_rc    <= SW'(rc_full);
      s0_err   <= err_c;
      s0_tag   <= in_tag;
    end
  end

  logic             pipe_valid [P];
  logic [MAXZ-1:0]  pipe_a     [P];
  logic [MAXZ-1:0]  pipe_b     [P];
  logic [MAXZ-1:0]  pipe_mask  [P];
  logic [SW-1:0]    pipe_r     [P];
  logic [SW-1:0]    pipe_rc    [P];
  logic             pipe_err   [P];
  logic [TAG_W-1:0] pipe_tag   [P];

  for (genvar g = 0; g < P; g++) begin : g_stage
    localparam int OFS = g * STAGES_PER_CYCLE;
    localparam int NL  = (g == P - 1) ? (LOG - OFS) : STAGES_PER_CYCLE;

    if (g == 0) begin : g_first
      qc_barrel_stage #(
        .MAXZ(MAXZ), .SW(SW), .TAG_W(TAG_W), .OFFSET(OFS), .N(NL)
      ) u_stage (
        .CLK(CLK), .rst(rst), .en(adv),
        .src_valid(s0_valid), .src_a(s0_x), .src_b(s0_x), .src_mask(s0_mask),
        .src_r(s0_r), .src_rc(s0_rc), .src_err(s0_err), .src_tag(s0_tag),
        .dst_valid(pipe_valid[g]), .dst_a(pipe_a[g]), .dst_b(pipe_b[g]),
        .dst_mask(pipe_mask[g]), .dst_r(pipe_r[g]), .dst_rc(pipe_rc[g]),
        .dst_err(pipe_err[g]), .dst_tag(pipe_tag[g])
      );
    end else begin : g_next
      qc_barrel_stage #(
        .MAXZ(MAXZ), .SW(SW), .TAG_W(TAG_W), .OFFSET(OFS), .N(NL)
      ) u_stage (
        .CLK(CLK), .rst(rst), .en(adv),
        .src_valid(pipe_valid[g-1]), .src_a(pipe_a[g-1]), .src_b(pipe_b[g-1]),
        .src_mask(pipe_mask[g-1]), .src_r(pipe_r[g-1]), .src_rc(pipe_rc[g-1]),
        .src_err(pipe_err[g-1]), .src_tag(pipe_tag[g-1]),
        .dst_valid(pipe_valid[g]), .dst_a(pipe_a[g]), .dst_b(pipe_b[g]),
        .dst_mask(pipe_mask[g]), .dst_r(pipe_r[g]), .dst_rc(pipe_rc[g]),
        .dst_err(pipe_err[g]), .dst_tag(pipe_tag[g])
      );
    end
  end

  // Merge the two shifted halves; the mask drops the wrapped copy above Z.
  always_ff @(posedge CLK) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= pipe_valid[P-1];
      out_data  <= pipe_err[P-1] ? '0 : ((pipe_a[P-1] | pipe_b[P-1]) & pipe_mask[P-1]);
      out_tag   <= pipe_tag[P-1];
      out_err   <= pipe_err[P-1];
    end
  end

endmodule

// File: tb/tb_qc_var_z_shifter.sv
// Randomized scoreboard bench for qc_var_z_shifter against a bit-level rotation model.
module tb_qc_var_z_shifter;
  import qc_ldpc_pkg::*;

  localparam int MAXZ = 16;
  localparam int TAG_W = 8;
  localparam int SW = 4;
  localparam int ZW = 5;
  localparam int LAT = 4;

  logic             CLK = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [MAXZ-1:0]  in_data;
  logic [SW-1:0]    in_shift;
  logic [ZW-1:0]    in_z;
  logic             in_dir;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [MAXZ-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  qc_var_z_shifter #(.MAXZ(MAXZ), .STAGES_PER_CYCLE(2), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_z(in_z), .in_dir(in_dir), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [MAXZ-1:0]  data;
    logic             err;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mode = 0;
  int stall_lo = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rotation straight from the definition: right moves bit (i+s)%Z to i, left moves i to (i+s)%Z.
  function automatic void refModel(input logic [MAXZ-1:0] d, input int sh, input int z,
                                   input bit left, output logic [MAXZ-1:0] o, output logic e);
    o = '0;
    e = (z == 0) || (z > MAXZ) || (sh >= z);
    if (!e) begin
      for (int i = 0; i < z; i++) begin
        if (!left) o[i] = d[(i + sh) % z];
        else       o[(i + sh) % z] = d[i];
      end
    end
  endfunction

  function automatic bit readyFor();
    case (mode)
      0:       return 1'b1;
      1:       return !((cyc >= stall_lo) && (cyc < stall_lo + 3));
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  function automatic shifter_beat_t mkBeat(input logic [15:0] d, input int sh, input int z,
                                           input shift_dir_e dir, input logic [7:0] tag);
    shifter_beat_t b;
    b.data = d; b.shift = SW'(sh); b.z = ZW'(z); b.dir = dir; b.tag = tag;
    return b;
  endfunction

  task automatic applyStimulus(input shifter_beat_t b, input bit lat);
    bit done = 1'b0;
    int guard = 0;
    exp_t e;
    while (!done) begin
      @(negedge CLK); #1;
      in_valid = 1'b1; in_data = b.data; in_shift = b.shift; in_z = b.z;
      in_dir = b.dir; in_tag = b.tag; out_ready = readyFor();
      #1;
      if (in_ready) begin
        refModel(b.data, int'(b.shift), int'(b.z), (b.dir == SHIFT_LEFT), e.data, e.err);
        e.tag = b.tag; e.acc = cyc + 1; e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end else if (++guard > 200) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      @(posedge CLK);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK); #1;
      in_valid = 1'b0; out_ready = readyFor();
    end
  endtask

  // Monitor: compares every presented beat with the scoreboard head, popping on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK); #3;
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_beat: got out_valid=1 tag 0x%0h, required no beat", out_tag);
        end else begin
          e = sb[0];
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_err", 32'(out_err), 32'(e.err));
          checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
          if (!out_ready) begin
            checkOutput("in_ready_stall", 32'(in_ready), 32'd0);
          end else begin
            if (e.lat) checkOutput("latency", 32'(cyc + 1 - e.acc), 32'(LAT));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    shifter_beat_t b;
    int z, sh;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_z = '0;
    in_dir = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
    checkOutput("reset_out_err", 32'(out_err), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    $display("[TB] directed beats");
    mode = 0;
    applyStimulus(mkBeat(16'h0001, 1, 16, SHIFT_RIGHT, 8'h01), 1);
    applyStimulus(mkBeat(16'h0003, 1, 10, SHIFT_RIGHT, 8'h02), 1);
    applyStimulus(mkBeat(16'h0201, 1, 10, SHIFT_LEFT,  8'h03), 1);
    applyStimulus(mkBeat(16'hFC01, 0, 10, SHIFT_RIGHT, 8'h04), 1);
    applyStimulus(mkBeat(16'h1234, 12, 10, SHIFT_RIGHT, 8'hA5), 1);
    applyStimulus(mkBeat(16'h00FF, 0, 0, SHIFT_LEFT,  8'h06), 1);
    applyStimulus(mkBeat(16'h00FF, 3, 20, SHIFT_RIGHT, 8'h07), 1);
    applyStimulus(mkBeat(16'hFFFE, 0, 1, SHIFT_RIGHT, 8'h08), 1);
    applyStimulus(mkBeat(16'hFFFF, 0, 1, SHIFT_LEFT,  8'h09), 1);
    applyStimulus(mkBeat(16'hBEEF, 0, 16, SHIFT_LEFT, 8'h0A), 1);
    applyStimulus(mkBeat(16'h8001, 15, 16, SHIFT_LEFT, 8'h0B), 1);
    idleCycles(LAT + 3);

    $display("[TB] backpressure stream");
    mode = 1;
    stall_lo = cyc + 6;
    for (int t = 0; t < 8; t++) begin
      z = $urandom_range(1, MAXZ);
      applyStimulus(mkBeat(16'($urandom), $urandom_range(0, z - 1), z,
                           shift_dir_e'($urandom_range(0, 1)), 8'(t)), 0);
    end
    idleCycles(LAT + 6);

    $display("[TB] reset with beats in flight");
    mode = 0;
    for (int t = 0; t < 3; t++) applyStimulus(mkBeat(16'hFFFF, 1, 16, SHIFT_RIGHT, 8'(8'hE0 + t)), 0);
    @(negedge CLK); #1;
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    @(posedge CLK); #2;
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK); #1 rst = 1'b0;
    applyStimulus(mkBeat(16'h0030, 4, 12, SHIFT_LEFT, 8'h5A), 1);
    idleCycles(LAT + 3);

    $display("[TB] random sweep");
    mode = 2;
    for (int n = 0; n < 1000; n++) begin
      z = $urandom_range(1, MAXZ);
      sh = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, z - 1);
      if ($urandom_range(0, 49) == 0) z = $urandom_range(0, 1) ? 0 : $urandom_range(17, 31);
      b = mkBeat(16'($urandom), sh, z, shift_dir_e'($urandom_range(0, 1)), 8'($urandom));
      applyStimulus(b, 0);
      if ($urandom_range(0, 7) == 0) idleCycles(1);
    end

    mode = 0;
    for (int k = 0; k < 200 && sb.size() > 0; k++) idleCycles(1);
    idleCycles(2);
    checkOutput("drain_outstanding", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
